// File: rtl/sigmoid_arbiter_pkg.sv
// Shared constants, tag type and ID-width helper for the sigmoid LUT arbiter.
package sigmoid_pkg;

  localparam int DEF_IN_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LUT_LAT    = 1;

  // Wide enough for the largest supported requester count (32).
  localparam int TAG_ID_W = 5;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sigmoid_arbiter_if.sv
// Neuron-side request/response bundle plus the LUT data path for the sigmoid arbiter.
interface sigmoid_arbiter_if
  import sigmoid_pkg::*;
#(
  parameter int N_REQ      = 8,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*IN_WIDTH-1:0]   req_data;
  logic [N_REQ-1:0]            req_ready;
  logic [IN_WIDTH-1:0]         lut_in;
  logic [DATA_WIDTH-1:0]       lut_out;
  logic [N_REQ-1:0]            rsp_valid;
  logic [N_REQ*DATA_WIDTH-1:0] rsp_data;
  logic                        busy;

  modport slave (
    input  req_valid, req_data, lut_out,
    output req_ready, lut_in, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_data, lut_out,
    input  req_ready, lut_in, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/sigmoid_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, wrapping at N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             any_req
);

  // Index wraps at N_REQ, so non-power-of-two counts never alias unused slots.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one sigmoid LUT between N_REQ neurons with round-robin grants and tagged returns.
// Optional statistics counters are built when SIGMOID_ARB_STATS_EN is defined.
module sigmoid_arbiter
  import sigmoid_pkg::*;
#(
  parameter int N_REQ      = 8,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LUT_LAT    = DEF_LUT_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SIGMOID_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] grant_cnt,
  output logic [31:0] stall_cnt,
`endif
  sigmoid_arbiter_if.slave bus
);

  localparam int ID_W = clog2_min1(N_REQ);

  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant_id;
  logic [N_REQ-1:0]    grant;
  logic                any_req;
  logic                accept;
  logic [IN_WIDTH-1:0] lut_in_q;
  tag_t                tags [LUT_LAT+1];
  tag_t                cap;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  assign bus.req_ready = rst_n ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign bus.lut_in    = accept ? bus.req_data[grant_id*IN_WIDTH +: IN_WIDTH] : lut_in_q;
  assign cap           = tags[LUT_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      lut_in_q <= '0;
    end else if (accept) begin
      ptr      <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      lut_in_q <= bus.lut_in;
    end
  end

  // The tag rides alongside the LUT latency so the result can be routed back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LUT_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{vld: accept, id: TAG_ID_W'(grant_id)};
      for (int i = 1; i <= LUT_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (cap.vld) begin
        bus.rsp_valid[cap.id]                          <= 1'b1;
        bus.rsp_data[cap.id*DATA_WIDTH +: DATA_WIDTH] <= bus.lut_out;
      end
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i <= LUT_LAT; i++) bus.busy = bus.busy | tags[i].vld;
  end

`ifdef SIGMOID_ARB_STATS_EN
  logic stall_now;
  assign stall_now = |(bus.req_valid & ~bus.req_ready);

  // Clear wins over increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (grant_cnt != 32'hFFFF_FFFF)) grant_cnt <= grant_cnt + 32'd1;
      if (stall_now && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
- Shares one sigmoid LUT instance between N_REQ neuron requesters in a layer, using round-robin arbitration.
- Each neuron presents its IN_WIDTH-bit pre-activation sum on a valid/ready handshake. The arbiter grants at most one request per cycle, drives the LUT input, and tags the request with its requester ID.
- The LUT result is returned to the owning neuron as a registered value plus a one-cycle valid pulse.
- Sits between the neuron array and the LUT. The LUT is external; this block only sequences it.

Parameters:
- N_REQ, 8, number of requesting neurons (2..32)
- IN_WIDTH, 10, LUT input width; matches the sigmoid LUT
- DATA_WIDTH, 16, LUT output width
- LUT_LAT, 1, cycles from LUT input sampled to LUT output valid (sigmoid LUT = 1)
- ID_W, $clog2(N_REQ), requester ID width (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request pending, per neuron
- req_data  in  N_REQ*IN_WIDTH  pre-activation per neuron; slice i = [i*IN_WIDTH +: IN_WIDTH]
- req_ready  out  N_REQ  one-hot grant/accept
- lut_in  out  IN_WIDTH  to the LUT data input
- lut_out  in  DATA_WIDTH  from the LUT data output
- rsp_valid  out  N_REQ  one-cycle result pulse, per neuron
- rsp_data  out  N_REQ*DATA_WIDTH  held result per neuron
- busy  out  1  any request accepted but not yet returned

Behaviour:
- Reset values:
  - rsp_valid = 0, rsp_data = 0, busy = 0.
  - RR pointer = 0; tag pipeline cleared.
  - req_ready = 0 while rst_n = 0.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo N_REQ; the first set bit is grant g.
  - req_ready = one-hot(g) if any req_valid is set, else 0.
  - req_ready depends only on req_valid and ptr, never on req_data.
- Accept: happens in a cycle where req_valid[g] & req_ready[g] = 1.
  - lut_in = slice g of req_data.
  - When no accept occurs, lut_in holds its previous value.
  - On the clock edge, ptr <= (g+1) mod N_REQ; with no accept, ptr is unchanged.
- Requester rule: hold req_valid and req_data stable until accepted. Deasserting req_valid before accept is legal and simply withdraws the request.
- Tag pipeline:
  - LUT_LAT+1 stages of {vld, id}.
  - Stage 0 is loaded on the accept edge; it advances every cycle with no stall.
  - The LUT output is never backpressured.
- Capture: when stage LUT_LAT-1 is valid with id k, rsp_data slice k <= lut_out at the end of that cycle, and rsp_valid[k] = 1 for exactly the next cycle.
- Latency: accept in cycle T gives rsp_valid in cycle T+LUT_LAT+1 (T+2 by default).
- Throughput: 1 result per cycle. A requester re-requesting every cycle gets one grant every N_REQ cycles under full load.
- rsp_data slices of other neurons are untouched; each slice holds its last value until overwritten.
- busy = OR of all tag-stage valids.
- Simultaneous events:
  - A grant and a response for the same neuron in the same cycle are independent.
  - Two responses can never coincide, because there is at most one accept per cycle.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is produced for them. Requesters must re-issue after reset.
- Arithmetic: ptr wraps at N_REQ, not 2**ID_W, when N_REQ is not a power of 2.

Optional Feature:
- Macro: SIGMOID_ARB_STATS_EN.
- When defined, adds the following, all reset to 0:
  - Output grant_cnt [31:0]: counts accepts.
  - Output stall_cnt [31:0]: counts cycles where |req_valid is set and at least one valid requester is not granted.
  - Input stats_clr [1]: synchronous clear of both counters, with priority over increment.
  - Counters saturate at 32'hFFFF_FFFF.
- When undefined, none of these ports or counters exist, and behaviour is otherwise identical.

Decomposition:
- Package sigmoid_pkg holds:
  - default IN_WIDTH/DATA_WIDTH/LUT_LAT constants;
  - function clog2_min1 for ID_W;
  - typedef of the tag struct {vld, id}.
- Natural sub-module: rr_arbiter (N_REQ requests, ptr in, one-hot grant + encoded id out, pure combinational). The pointer register stays in sigmoid_arbiter.

Test Plan:
- The bench uses a model LUT with mem[i] = i, so the response equals the LUT index: rsp = zero-extended (data_in XOR 10'h200).
1. Single request: neuron 3 sends 10'h005 in cycle T.
   - req_ready = 8'b0000_1000 in T.
   - rsp_valid[3] pulses in T+2; rsp_data[3] = 16'h0205.
2. Negative input: neuron 0 sends 10'h3FF.
   - Result 16'h01FF, 2 cycles after accept.
3. All 8 neurons valid continuously from reset.
   - Grants run 0,1,…,7,0 on consecutive cycles.
   - One rsp_valid per cycle with matching ID, 2 cycles after each grant.
4. Wrap/non-power-of-2: N_REQ = 5, ptr = 4, valids on 1 and 4.
   - Grant 4, then 1; ptr never reaches 5–7.
5. Reset mid-flight: assert rst_n = 0 in the cycle after neuron 2's accept.
   - No rsp_valid[2]; all outputs 0.
   - First grant after release is to the lowest valid index ≥ 0.
6. Stats (SIGMOID_ARB_STATS_EN): 3 neurons valid for 4 cycles.
   - grant_cnt = 4, stall_cnt = 4.
   - stats_clr pulse sets both counters to 0 in the next cycle.
